// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_param
// Description : Parameterised register file with two combinational read
//               ports, one byte-masked write port, optional hard-wired zero
//               register, optional write-to-read forwarding and a per-register
//               pending (scoreboard) bit set at issue and cleared at write.
// Ports       : clk, reset (async, active-high)
//               write_enable, reg_dest, data_input, byte_en  - write port
//               reg_src1/2 -> read_data1/2, busy1/2          - read ports
//               issue_valid, issue_dest                      - scoreboard set
//               hazard = busy1 | busy2
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_param #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int ZERO_REG     = 1,
    parameter int BYPASS       = 1,
    parameter int ONE_REG_INIT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write_enable,
    input  logic [ADDR_W-1:0]   reg_dest,
    input  logic [DATA_W-1:0]   data_input,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic [ADDR_W-1:0]   reg_src1,
    input  logic [ADDR_W-1:0]   reg_src2,
    output logic [DATA_W-1:0]   read_data1,
    output logic [DATA_W-1:0]   read_data2,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_dest,
    output logic                busy1,
    output logic                busy2,
    output logic                hazard
);

    localparam int          c_DEPTH = 2 ** ADDR_W;
    localparam int          c_NB    = DATA_W / 8;
    localparam logic [DATA_W-1:0] c_ONE = DATA_W'(1);

    logic [DATA_W-1:0] regs_q [c_DEPTH];
    logic [DATA_W-1:0] regs_d [c_DEPTH];
    logic [c_DEPTH-1:0] busy_q;
    logic [c_DEPTH-1:0] busy_d;

    logic              w_wr_ok;
    logic              w_iss_ok;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_merged;

    // Writes and issues to register 0 are dropped when it is hard-wired.
    // Gating with reset also keeps forwarding quiet while reset is held.
    assign w_wr_ok  = write_enable && !reset &&
                      !((ZERO_REG != 0) && (reg_dest == '0));
    assign w_iss_ok = issue_valid && !reset &&
                      !((ZERO_REG != 0) && (issue_dest == '0));

    generate
        for (genvar i = 0; i < c_NB; i++) begin : g_mask
            assign w_mask[8*i +: 8] = {8{byte_en[i]}};
        end
    endgenerate

    // Byte-merged value the destination will hold after the edge.
    assign w_merged = (regs_q[reg_dest] & ~w_mask) | (data_input & w_mask);

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (w_wr_ok) begin
            regs_d[reg_dest] = w_merged;
            busy_d[reg_dest] = 1'b0;
        end
        // Issue applied last so a same-edge issue beats the clearing write.
        if (w_iss_ok) begin
            busy_d[issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                regs_q[i] <= ((ONE_REG_INIT != 0) && (i == 1)) ? c_ONE : '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Two identical read ports.
    logic [ADDR_W-1:0] w_src   [2];
    logic [DATA_W-1:0] w_rdata [2];
    logic              w_rbusy [2];

    assign w_src[0] = reg_src1;
    assign w_src[1] = reg_src2;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rd
            always_comb begin
                w_rdata[p] = regs_q[w_src[p]];
                w_rbusy[p] = busy_q[w_src[p]];
                if ((ZERO_REG != 0) && (w_src[p] == '0)) begin
                    w_rdata[p] = '0;
                    w_rbusy[p] = 1'b0;
                end else if ((BYPASS != 0) && w_wr_ok && (reg_dest == w_src[p])) begin
                    // Forwarded write also resolves the pending state early.
                    w_rdata[p] = w_merged;
                    w_rbusy[p] = 1'b0;
                end
            end
        end
    endgenerate

    assign read_data1 = w_rdata[0];
    assign read_data2 = w_rdata[1];
    assign busy1      = w_rbusy[0];
    assign busy2      = w_rbusy[1];
    assign hazard     = w_rbusy[0] | w_rbusy[1];

endmodule
`default_nettype wire
